// File: rtl/par_check_pkg.sv
// rtl/par_check_pkg.sv - shared types and constants for the stream parity checker
// Contents:
//   state_t            frame FSM state (IDLE, ACCUM, RESULT)
//   PAR_EVEN/PAR_ODD   values for the ODD parameter
package par_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/par_lane.sv
// rtl/par_lane.sv - parity fail detector for a single data lane
// Ports:
//   data  lane data bits
//   par   transmitted parity bit for this lane
//   fail  1 when data and par together do not carry the expected parity
module par_lane
  import par_check_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = PAR_EVEN
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              fail
);

  logic expect_odd;

  assign expect_odd = (ODD != PAR_EVEN);
  assign fail       = ((^data) ^ par) != expect_odd;

endmodule

// File: rtl/par_check_stream.sv
// rtl/par_check_stream.sv - per-lane parity checker producing one result per frame
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready               beat handshake
//   in_data, in_par, in_last        LANES lanes of DATA_W data, per-lane parity, frame end
//   out_valid/out_ready             frame result handshake
//   out_err_mask, out_ok, out_beats failing lanes, no-fail flag, saturating beat count
//   clr                             clears err_count and sticky_err
//   err_count, sticky_err           saturating failed-frame count, sticky failure flag
module par_check_stream
  import par_check_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16,
  parameter int ODD    = PAR_EVEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_par,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_err_mask,
  output logic                    out_ok,
  output logic [CNT_W-1:0]        out_beats,
  input  logic                    clr,
  output logic [CNT_W-1:0]        err_count,
  output logic                    sticky_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic [LANES-1:0] beat_fail;
  logic [LANES-1:0] acc_mask;
  logic [LANES-1:0] frame_mask;
  logic [CNT_W-1:0] acc_beats;
  logic [CNT_W-1:0] frame_beats;
  logic             accept;
  logic             close;
  logic             close_fail;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    par_lane #(
      .DATA_W (DATA_W),
      .ODD    (ODD)
    ) u_lane (
      .data (in_data[g*DATA_W +: DATA_W]),
      .par  (in_par[g]),
      .fail (beat_fail[g])
    );
  end

  assign out_valid = (state == RESULT);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign close     = accept && in_last;

  // Accumulators are zeroed whenever a frame closes, so a beat taken while a
  // result is retiring naturally starts the next frame from zero.
  assign frame_mask  = acc_mask | beat_fail;
  assign frame_beats = (acc_beats == CNT_MAX) ? acc_beats : acc_beats + 1'b1;
  assign close_fail  = close && (frame_mask != '0);

  assign out_ok = (out_err_mask == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nxt = in_last ? RESULT : ACCUM;
        end
      end
      RESULT: begin
        if (accept) begin
          state_nxt = in_last ? RESULT : ACCUM;
        end else if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_mask     <= '0;
      acc_beats    <= '0;
      out_err_mask <= '0;
      out_beats    <= '0;
      err_count    <= '0;
      sticky_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (in_last) begin
          out_err_mask <= frame_mask;
          out_beats    <= frame_beats;
          acc_mask     <= '0;
          acc_beats    <= '0;
        end else begin
          acc_mask     <= frame_mask;
          acc_beats    <= frame_beats;
        end
      end

      // clr wins over the old count but a frame failing on the same edge
      // still counts, so the result is 1 rather than 0.
      if (clr) begin
        err_count  <= CNT_W'(close_fail);
        sticky_err <= close_fail;
      end else begin
        if (close_fail && (err_count != CNT_MAX)) begin
          err_count <= err_count + 1'b1;
        end
        sticky_err <= sticky_err | close_fail;
      end
    end
  end

endmodule

// File: tb/tb_par_check_stream.sv
// tb/tb_par_check_stream.sv - self-checking bench for par_check_stream
module tb_par_check_stream;

  localparam logic [31:0] GOOD   = 32'h0103_00FF;
  localparam logic [3:0]  GOOD_P = 4'b1000;
  localparam int          MAXC   = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_par = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr = 1'b0;

  logic        rdy0, vld0, ok0, stk0;
  logic [3:0]  msk0;
  logic [15:0] bts0, err0;
  logic        rdy1, vld1, ok1, stk1;
  logic [3:0]  msk1;
  logic [15:0] bts1, err1;
  logic        rdy2, vld2, ok2, stk2;
  logic [3:0]  msk2;
  logic [1:0]  bts2, err2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  par_check_stream dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_err_mask(msk0), .out_ok(ok0), .out_beats(bts0), .clr(clr),
    .err_count(err0), .sticky_err(stk0)
  );

  par_check_stream #(.ODD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_err_mask(msk1), .out_ok(ok1), .out_beats(bts1), .clr(clr),
    .err_count(err1), .sticky_err(stk1)
  );

  par_check_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
    .out_err_mask(msk2), .out_ok(ok2), .out_beats(bts2), .clr(clr),
    .err_count(err2), .sticky_err(stk2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model of dut0 (even parity, 16-bit counters).
  bit         m_res_valid = 1'b0;
  logic [3:0] m_open_mask = '0;
  logic [3:0] m_res_mask  = '0;
  int         m_open_beats = 0;
  int         m_res_beats  = 0;
  int         m_errs       = 0;
  bit         m_sticky     = 1'b0;

  always @(posedge clk) begin
    logic [3:0] f;
    bit         rdy;
    if (rst) begin
      m_res_valid  = 1'b0;
      m_open_mask  = '0;
      m_res_mask   = '0;
      m_open_beats = 0;
      m_res_beats  = 0;
      m_errs       = 0;
      m_sticky     = 1'b0;
    end else begin
      rdy = !m_res_valid || out_ready;
      if (m_res_valid && out_ready) m_res_valid = 1'b0;
      if (clr) begin
        m_errs   = 0;
        m_sticky = 1'b0;
      end
      if (in_valid && rdy) begin
        for (int i = 0; i < 4; i++) begin
          f[i] = ((($countones(in_data[i*8 +: 8]) + int'(in_par[i])) % 2) != 0);
        end
        m_open_mask  = m_open_mask | f;
        m_open_beats = (m_open_beats < MAXC) ? m_open_beats + 1 : MAXC;
        if (in_last) begin
          m_res_valid = 1'b1;
          m_res_mask  = m_open_mask;
          m_res_beats = m_open_beats;
          if (m_res_mask != 0) begin
            m_errs   = (m_errs < MAXC) ? m_errs + 1 : MAXC;
            m_sticky = 1'b1;
          end
          m_open_mask  = '0;
          m_open_beats = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_in_ready", 32'(rdy0), 32'(!m_res_valid || out_ready));
    chk("m_out_valid", 32'(vld0), 32'(m_res_valid));
    if (m_res_valid) begin
      chk("m_err_mask", 32'(msk0), 32'(m_res_mask));
      chk("m_out_ok", 32'(ok0), 32'(m_res_mask == 0));
      chk("m_out_beats", 32'(bts0), 32'(m_res_beats));
    end
    chk("m_err_count", 32'(err0), 32'(m_errs));
    chk("m_sticky", 32'(stk0), 32'(m_sticky));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] p, input logic l, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = l;
    clr      = c;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    // reset state
    chk("rst_in_ready", 32'(rdy0), 32'd1);
    chk("rst_out_valid", 32'(vld0), 32'd0);
    chk("rst_mask", 32'(msk0), 32'd0);
    chk("rst_ok", 32'(ok0), 32'd1);
    chk("rst_beats", 32'(bts0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_sticky", 32'(stk0), 32'd0);

    // single good beat
    send(GOOD, GOOD_P, 1'b1, 1'b0);
    chk("one_valid", 32'(vld0), 32'd1);
    chk("one_mask", 32'(msk0), 32'd0);
    chk("one_ok", 32'(ok0), 32'd1);
    chk("one_beats", 32'(bts0), 32'd1);
    tick();

    // 3 beats, par[2] flipped on beat 2
    send(GOOD, GOOD_P, 1'b0, 1'b0);
    send(GOOD, 4'b1100, 1'b0, 1'b0);
    send(GOOD, GOOD_P, 1'b1, 1'b0);
    chk("three_mask", 32'(msk0), 32'h4);
    chk("three_beats", 32'(bts0), 32'd3);
    chk("three_err", 32'(err0), 32'd1);
    chk("three_sticky", 32'(stk0), 32'd1);
    tick();

    // result held under backpressure, then retire with back-to-back beat
    out_ready = 1'b0;
    send(32'h0, 4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_in_ready", 32'(rdy0), 32'd0);
      chk("hold_valid", 32'(vld0), 32'd1);
      chk("hold_mask", 32'(msk0), 32'h1);
      chk("hold_beats", 32'(bts0), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    send(GOOD, GOOD_P, 1'b1, 1'b0);
    chk("b2b_valid", 32'(vld0), 32'd1);
    chk("b2b_mask", 32'(msk0), 32'd0);
    chk("b2b_beats", 32'(bts0), 32'd1);
    chk("b2b_err", 32'(err0), 32'd2);

    // odd-parity instance
    send(32'h0, 4'b1111, 1'b1, 1'b0);
    chk("odd_ok", 32'(ok1), 32'd1);
    chk("odd_mask0", 32'(msk1), 32'd0);
    chk("even_mask_all", 32'(msk0), 32'hF);
    send(32'h0, 4'b0000, 1'b1, 1'b0);
    chk("odd_mask_all", 32'(msk1), 32'hF);
    chk("odd_nok", 32'(ok1), 32'd0);

    // reset mid-frame
    send(GOOD, 4'b0000, 1'b0, 1'b0);
    send(GOOD, GOOD_P, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready", 32'(rdy0), 32'd1);
    chk("mid_valid", 32'(vld0), 32'd0);
    chk("mid_err", 32'(err0), 32'd0);
    chk("mid_sticky", 32'(stk0), 32'd0);
    send(GOOD, GOOD_P, 1'b1, 1'b0);
    chk("mid_beats", 32'(bts0), 32'd1);
    chk("mid_mask", 32'(msk0), 32'd0);

    // beat count saturation on CNT_W=2
    for (int k = 0; k < 5; k++) send(GOOD, GOOD_P, (k == 4), 1'b0);
    chk("sat_beats2", 32'(bts2), 32'd3);
    chk("sat_beats0", 32'(bts0), 32'd5);
    chk("sat_err2_zero", 32'(err2), 32'd0);

    // err_count saturation, then clr coinciding with a failed close
    for (int k = 0; k < 5; k++) send(32'h0, 4'b0001, 1'b1, 1'b0);
    chk("errsat2", 32'(err2), 32'd3);
    chk("errsat2_sticky", 32'(stk2), 32'd1);
    chk("err5_dut0", 32'(err0), 32'd5);
    send(32'h0, 4'b0001, 1'b1, 1'b1);
    chk("clrfail2_err", 32'(err2), 32'd1);
    chk("clrfail2_sticky", 32'(stk2), 32'd1);
    chk("clrfail0_err", 32'(err0), 32'd1);

    // plain clr
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err2", 32'(err2), 32'd0);
    chk("clr_sticky2", 32'(stk2), 32'd0);
    chk("clr_err0", 32'(err0), 32'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/par_check_stream.md
PAR_CHECK_STREAM -- requirements
Module: par_check_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data bits per lane.
REQ-002 The block SHALL have parameter LANES, default 4: independent parity channels per beat.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the error counter and beat counter.
REQ-004 The block SHALL have parameter ODD, default 0: 0 = even parity expected, 1 = odd parity expected.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1: a beat is presented.
REQ-008 The block SHALL have port in_ready, output, 1: the beat is accepted when in_valid && in_ready.
REQ-009 The block SHALL have port in_data, input, LANES*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port in_par, input, LANES: bit i is the transmitted parity bit of lane i.
REQ-011 The block SHALL have port in_last, input, 1: the beat closes the current frame.
REQ-012 The block SHALL have port out_valid, input/output direction output, 1: the frame result is held.
REQ-013 The block SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-014 The block SHALL have port out_err_mask, output, LANES: lanes that failed on at least one beat of the frame.
REQ-015 The block SHALL have port out_ok, output, 1: asserted when out_err_mask == 0.
REQ-016 The block SHALL have port out_beats, output, CNT_W: number of beats in the frame, saturating.
REQ-017 The block SHALL have port clr, input, 1: clears err_count and sticky_err.
REQ-018 The block SHALL have port err_count, output, CNT_W: number of failed frames, saturating at all-ones.
REQ-019 The block SHALL have port sticky_err, output, 1: set by any failed frame; held until clr or rst.

Function
REQ-020 Per accepted beat, lane i SHALL fail when (XOR of lane i data) ^ in_par[i] != ODD.
REQ-021 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-022 The FSM SHALL have three states: IDLE (no open frame), ACCUM (open frame), and RESULT (out_valid=1).
REQ-023 In IDLE or ACCUM, an accepted beat SHALL OR its per-lane fails into the accumulated mask and increment the beat count.
REQ-024 On an accepted beat with in_last=0, the FSM SHALL go to ACCUM.
REQ-025 On an accepted beat with in_last=1, the FSM SHALL go to RESULT. The result registers SHALL be loaded with the final mask, including this beat, and the final beat count.
REQ-026 Latency: a last beat accepted at edge N SHALL produce out_valid=1 from N+1.
REQ-027 A single-beat frame (in_last=1 in IDLE) SHALL be legal and SHALL produce out_beats=1.
REQ-028 In RESULT, outputs SHALL hold stable while out_ready=0.
REQ-029 In RESULT with out_ready=1, the result SHALL retire. A beat accepted in the same cycle SHALL start the next frame from a zero mask and zero count, with no bubble.
REQ-030 Accumulators SHALL clear after each frame closes.
REQ-031 The beat count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-032 err_count SHALL increment once per failed frame, on the edge the frame closes, and SHALL saturate.
REQ-033 When clr coincides with a failed frame closing, err_count SHALL become 1 and sticky_err SHALL become 1.

Reset
REQ-034 While rst=1, the block SHALL go to IDLE on the next edge. It SHALL drive out_valid=0, out_err_mask=0, out_ok=1, out_beats=0, err_count=0 and sticky_err=0, and it SHALL clear the accumulators.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame without counting it.
REQ-036 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-037 A shared package par_check_pkg SHALL hold the state enum (IDLE, ACCUM, RESULT) and the ODD/EVEN mode constants.
REQ-038 One sub-module, par_lane, SHALL compute the fail bit for one lane. It SHALL be instantiated LANES times by generate.

Verification
REQ-039 The bench SHALL cover this scenario. Stimulus: defaults; one beat, data 0x01_03_00_FF, par 4'b1000, last=1. Required response: one cycle later out_valid=1, out_err_mask=0, out_ok=1, out_beats=1.
REQ-040 The bench SHALL cover this scenario. Stimulus: 3-beat frame where beat 2 has a flipped par[2]. Required response: out_err_mask=4'b0100, out_beats=3, err_count=1, sticky_err=1.
REQ-041 The bench SHALL cover this scenario. Stimulus: out_ready=0 for 5 cycles after a result. Required response: in_ready=0 and outputs held. Then out_ready=1 together with an in_valid last beat: the result retires and the new result appears on the next cycle.
REQ-042 The bench SHALL cover this scenario. Stimulus: ODD=1, data 0x00 per lane, par all 1. Required response: out_ok=1. Then par all 0: out_err_mask=4'b1111.
REQ-043 The bench SHALL cover this scenario. Stimulus: rst pulse after 2 beats of an open frame. Required response: out_valid=0, err_count=0, and the next 1-beat frame reports out_beats=1.
REQ-044 The bench SHALL cover this scenario. Stimulus: CNT_W=2, 5 failed frames, then clr on the cycle a 6th failed frame closes. Required response: err_count saturates at 3, then reads 1 after the clr; sticky_err=1.
